mux4_rr_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 38 +++
 rtl/mux4_dp.sv | 37 +++
 rtl/mux4_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the four-way round-robin multiplexer arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // First asserted request scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] ptr);
        rr_pick_t   pick;
        logic [1:0] cand;
        pick.found = 1'b0;
        pick.idx   = 2'b00;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + 2'(i);
            if (!pick.found && req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end else begin
                pick.found = pick.found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_dp.sv
// Combinational 4:1 data path; forces zero when no grant is active.
module mux4_dp
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    input  logic [1:0]                sel,
    input  logic                      valid,
    output logic [DATA_W-1:0]         data_o
);

    logic [DATA_W-1:0] w_lane;

    // Pick the selected lane
    always_comb begin
        w_lane = {DATA_W{1'b0}};
        case (sel)
            2'd0:    w_lane = data_i[0*DATA_W +: DATA_W];
            2'd1:    w_lane = data_i[1*DATA_W +: DATA_W];
            2'd2:    w_lane = data_i[2*DATA_W +: DATA_W];
            2'd3:    w_lane = data_i[3*DATA_W +: DATA_W];
            default: w_lane = {DATA_W{1'b0}};
        endcase
    end

    // Gate the lane with valid so an idle path reads as zero
    always_comb begin
        data_o = {DATA_W{1'b0}};
        if (valid) begin
            data_o = w_lane;
        end else begin
            data_o = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data path; grants are held for at most
// HOLD_MAX cycles before priority rotates away from the current grantee.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [1:0]                sel,
    output logic                      valid,
    output logic [DATA_W-1:0]         data_o
);

    arb_state_e         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [1:0]         r_sel;
    logic               r_valid;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [1:0]         r_ptr;

    rr_pick_t w_pick_idle;
    rr_pick_t w_pick_rel;
    logic     w_quantum_end;
    logic     w_keep;

    // On release the search restarts just after the releasing lane, so it
    // uses r_sel directly rather than waiting for r_ptr to update.
    assign w_pick_idle   = rr_pick(req, r_ptr);
    assign w_pick_rel    = rr_pick(req, r_sel);
    assign w_quantum_end = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
    assign w_keep        = req[r_sel] && !w_quantum_end;

    // Arbiter state machine with registered grant outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'b00;
            r_valid    <= 1'b0;
            r_hold_cnt <= {CNT_W{1'b0}};
            r_ptr      <= 2'b11;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hold_cnt <= {CNT_W{1'b0}};
                    if (w_pick_idle.found) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= idx_to_onehot(w_pick_idle.idx);
                        r_sel   <= w_pick_idle.idx;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_sel   <= 2'b00;
                        r_valid <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_keep) begin
                        r_hold_cnt <= r_hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_ptr      <= r_sel;
                        r_hold_cnt <= {CNT_W{1'b0}};
                        if (w_pick_rel.found) begin
                            r_state <= ST_GRANT;
                            r_gnt   <= idx_to_onehot(w_pick_rel.idx);
                            r_sel   <= w_pick_rel.idx;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= 4'b0000;
                            r_sel   <= 2'b00;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_gnt      <= 4'b0000;
                    r_sel      <= 2'b00;
                    r_valid    <= 1'b0;
                    r_hold_cnt <= {CNT_W{1'b0}};
                    r_ptr      <= 2'b11;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;

    mux4_dp #(
        .DATA_W (DATA_W)
    ) u_dp (
        .data_i (data_i),
        .sel    (r_sel),
        .valid  (r_valid),
        .data_o (data_o)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and random stimulus on HOLD_MAX=4 and HOLD_MAX=1 instances, checked
// against a queue-free behavioural round-robin model.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] data_i = 4'b0000;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       valid_a, valid_b;
    logic [0:0] dout_a, dout_b;

    int vectors = 0;
    int miscompares = 0;

    int owner [2];
    int held  [2];
    int ptr   [2];
    int hmax  [2] = '{4, 1};

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DATA_W(1), .HOLD_MAX(4), .CNT_W(4)) u_dut_h4 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_i(data_i),
        .gnt(gnt_a), .sel(sel_a), .valid(valid_a), .data_o(dout_a)
    );

    mux4_rr_arbiter #(.DATA_W(1), .HOLD_MAX(1), .CNT_W(4)) u_dut_h1 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_i(data_i),
        .gnt(gnt_b), .sel(sel_b), .valid(valid_b), .data_o(dout_b)
    );

    function automatic int rr_find(input logic [3:0] r, input int p);
        for (int j = 1; j <= 4; j++) begin
            if (r[(p + j) % 4]) return (p + j) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1;
            held[m]  = 0;
            ptr[m]   = 3;
        end
    endtask

    // held counts granted cycles including the current one
    task automatic model_step(input int m);
        if (owner[m] < 0) begin
            owner[m] = rr_find(req, ptr[m]);
            held[m]  = (owner[m] >= 0) ? 1 : 0;
        end else if (req[owner[m]] && held[m] < hmax[m]) begin
            held[m] = held[m] + 1;
        end else begin
            ptr[m]   = owner[m];
            owner[m] = rr_find(req, ptr[m]);
            held[m]  = (owner[m] >= 0) ? 1 : 0;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        logic [3:0] eg;
        logic [1:0] es;
        logic       ev;
        logic       ed;
        for (int m = 0; m < 2; m++) begin
            ev = (owner[m] >= 0);
            eg = ev ? (4'b0001 << owner[m]) : 4'b0000;
            es = ev ? 2'(owner[m]) : 2'b00;
            ed = ev ? data_i[owner[m]] : 1'b0;
            chk($sformatf("%s/h%0d gnt", ph, hmax[m]), (m == 0) ? gnt_a : gnt_b, eg);
            chk($sformatf("%s/h%0d sel", ph, hmax[m]), {2'b00, (m == 0) ? sel_a : sel_b}, {2'b00, es});
            chk($sformatf("%s/h%0d valid", ph, hmax[m]), {3'b000, (m == 0) ? valid_a : valid_b}, {3'b000, ev});
            chk($sformatf("%s/h%0d data_o", ph, hmax[m]), {3'b000, (m == 0) ? dout_a : dout_b}, {3'b000, ed});
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] d, input string ph);
        req    = r;
        data_i = d;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all(ph);
    endtask

    // Asserts reset mid-cycle, checks outputs clear before any clock edge
    task automatic do_reset(input string ph);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        chk({ph, " gnt_zero"}, gnt_a, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        chk("reset gnt_a", gnt_a, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 4'b0000, "idle");
        step(4'b0010, 4'b0010, "pre_rst");
        step(4'b0010, 4'b0010, "pre_rst");
        chk("pre_rst gnt_a", gnt_a, 4'b0010);
        do_reset("mid_grant_rst");
        step(4'b1001, 4'b1001, "post_rst");
        chk("post_rst first_gnt", gnt_a, 4'b0001);

        do_reset("rst2");
        for (int i = 0; i < 13; i++) step(4'b0100, 4'b0100, "single");
        chk("single gnt_a", gnt_a, 4'b0100);

        for (int i = 0; i < 21; i++) step(4'b1111, 4'($urandom), "contend");
        for (int i = 0; i < 2; i++) step(4'b0000, 4'b0000, "drain");

        do_reset("rst3");
        for (int i = 0; i < 3; i++) step(4'b0011, 4'b0011, "early");
        chk("early gnt_a", gnt_a, 4'b0001);
        step(4'b0010, 4'b0011, "early_drop0");
        chk("early_drop0 gnt_a", gnt_a, 4'b0010);
        step(4'b0010, 4'b0010, "early_hold1");
        step(4'b0000, 4'b0010, "early_drop1");
        chk("early_drop1 gnt_a", gnt_a, 4'b0000);

        step(4'b0101, 4'b0101, "fair");
        chk("fair first", gnt_a, 4'b0100);
        for (int i = 0; i < 5; i++) step(4'b0101, 4'b0001, "fair");
        chk("fair second", gnt_a, 4'b0001);

        for (int i = 0; i < 8; i++) step(4'b1010, 4'($urandom), "alt");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
            step(4'($urandom) & 4'($urandom | ($urandom >> 4)), 4'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
